// File: rtl/ecn_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ecn_pkg
//  Description : Shared widths, FSM state encoding and a constant clog2 helper
//                for the check-node output selection stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package ecn_pkg;

  localparam int ECN_LLR_WIDTH    = 5;
  localparam int ECN_Q_WIDTH      = 6;
  localparam int ECN_INDEXA_WIDTH = 5;
  localparam int ECN_INDEXI_WIDTH = 5;
  localparam int ECN_N_OUT        = 16;
  localparam int ECN_N_POP_MAX    = 32;
  localparam int ECN_I_LEN        = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } ecn_state_t;

  // Smallest r with 2**r >= value, never less than 1 so that derived
  // vectors always have at least one bit.
  function automatic int ecn_clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gf_seen_bitmap.sv
`default_nettype none
// ============================================================================
//  Module      : gf_seen_bitmap
//  Description : One flag per GF symbol recording whether it was already
//                emitted in the current round. Synchronous clear, combinational
//                lookup, set on request. Used only when ECN_DEDUP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module gf_seen_bitmap #(
  parameter int Q_Width = 6
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           clear,
  input  logic           set_en,
  input  logic [Q_Width:0] addr,
  output logic           hit
);

  localparam int DEPTH = 2 ** (Q_Width + 1);

  logic [DEPTH-1:0] flags;

  assign hit = flags[addr];

  // Flag storage: clear wins over a simultaneous set so a new round starts empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flags <= '0;
    end else if (clear) begin
      flags <= '0;
    end else if (set_en) begin
      flags[addr] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ecn_output_select.sv
`default_nettype none
// ============================================================================
//  Module      : ecn_output_select
//  Description : Drains the head of the sorted candidate list, drops GF symbols
//                already emitted (when ECN_DEDUP_EN is defined), normalizes
//                accepted LLRs to the first accepted one and streams up to
//                N_OUT unique pairs. Every pop also requests the follow-on
//                candidate (IndexA, IndexI+1) while it exists.
//                Optional macro: ECN_DEDUP_EN (duplicate filtering).
//  Revision    : 1.0 - initial release
// ============================================================================
module ecn_output_select
  import ecn_pkg::*;
#(
  parameter int LLR_Width    = ECN_LLR_WIDTH,
  parameter int Q_Width      = ECN_Q_WIDTH,
  parameter int IndexA_Width = ECN_INDEXA_WIDTH,
  parameter int IndexI_Width = ECN_INDEXI_WIDTH,
  parameter int N_OUT        = ECN_N_OUT,
  parameter int N_POP_MAX    = ECN_N_POP_MAX,
  parameter int I_LEN        = ECN_I_LEN
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         head_valid,
  input  logic [LLR_Width:0]           head_LLR,
  input  logic [Q_Width:0]             head_Q,
  input  logic [IndexA_Width:0]        head_IndexA,
  input  logic [IndexI_Width:0]        head_IndexI,
  output logic                         pop,
  output logic                         nxt_valid,
  output logic [IndexA_Width:0]        nxt_IndexA,
  output logic [IndexI_Width:0]        nxt_IndexI,
  output logic                         out_valid,
  output logic [LLR_Width:0]           out_LLR,
  output logic [Q_Width:0]             out_Q,
  output logic [ecn_clog2(N_OUT)-1:0]  out_pos,
  output logic                         done,
  output logic                         busy
);

  localparam int POS_W  = ecn_clog2(N_OUT);
  localparam int OCNT_W = ecn_clog2(N_OUT + 1);
  localparam int PCNT_W = ecn_clog2(N_POP_MAX + 1);
  localparam int IDXW   = IndexI_Width + 2;

  localparam logic [OCNT_W-1:0] N_OUT_C     = OCNT_W'(N_OUT);
  localparam logic [PCNT_W-1:0] N_POP_C     = PCNT_W'(N_POP_MAX);
  localparam logic [IDXW-1:0]   I_LEN_C     = IDXW'(I_LEN);
  localparam logic [IDXW-1:0]   IDX_ONE     = IDXW'(1);
  localparam logic [OCNT_W-1:0] OCNT_ONE    = OCNT_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_ONE    = PCNT_W'(1);

  ecn_state_t state;
  ecn_state_t state_nxt;

  logic [OCNT_W-1:0]   out_cnt;
  logic [PCNT_W-1:0]   pop_cnt;
  logic [LLR_Width:0]  base;
  logic                base_valid;

  logic                seen_hit;
  logic                accept;
  logic                term;
  logic                nxt_ok;
  logic [IDXW-1:0]     idx_inc;
  logic [OCNT_W-1:0]   out_cnt_inc;
  logic [PCNT_W-1:0]   pop_cnt_inc;
  logic [LLR_Width:0]  norm_llr;

`ifdef ECN_DEDUP_EN
  gf_seen_bitmap #(
    .Q_Width (Q_Width)
  ) u_seen (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start),
    .set_en  (accept),
    .addr    (head_Q),
    .hit     (seen_hit)
  );
`else
  assign seen_hit = 1'b0;
`endif

  assign out_cnt_inc = out_cnt + OCNT_ONE;
  assign pop_cnt_inc = pop_cnt + PCNT_ONE;
  assign idx_inc     = {1'b0, head_IndexI} + IDX_ONE;
  assign nxt_ok      = (idx_inc < I_LEN_C);

  // A start in the same cycle wipes the round, so it suppresses acceptance.
  assign accept = pop & ~start & ~seen_hit & (out_cnt < N_OUT_C);
  assign term   = pop & ~start &
                  ((accept && (out_cnt_inc == N_OUT_C)) || (pop_cnt_inc == N_POP_C));

  // Normalized LLR: zero for the first accepted entry, clamp on ordering violations.
  always_comb begin
    norm_llr = '0;
    if (base_valid && (head_LLR >= base)) begin
      norm_llr = head_LLR - base;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state and status outputs; start outranks termination.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_RUN: begin
        pop  = head_valid;
        busy = 1'b1;
        if (term) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (start) state_nxt = ST_RUN;
  end

  // Round counters, normalization base and the registered output/request stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_cnt    <= '0;
      pop_cnt    <= '0;
      base       <= '0;
      base_valid <= 1'b0;
      out_valid  <= 1'b0;
      out_LLR    <= '0;
      out_Q      <= '0;
      out_pos    <= '0;
      nxt_valid  <= 1'b0;
      nxt_IndexA <= '0;
      nxt_IndexI <= '0;
    end else begin
      out_valid  <= 1'b0;
      out_LLR    <= '0;
      out_Q      <= '0;
      out_pos    <= '0;
      nxt_valid  <= 1'b0;
      nxt_IndexA <= '0;
      nxt_IndexI <= '0;

      // The consumed head always needs its successor, even on a duplicate.
      if (pop && nxt_ok) begin
        nxt_valid  <= 1'b1;
        nxt_IndexA <= head_IndexA;
        nxt_IndexI <= idx_inc[IndexI_Width:0];
      end

      if (start) begin
        out_cnt    <= '0;
        pop_cnt    <= '0;
        base       <= '0;
        base_valid <= 1'b0;
      end else if (pop) begin
        pop_cnt <= pop_cnt_inc;
        if (accept) begin
          out_valid <= 1'b1;
          out_Q     <= head_Q;
          out_pos   <= out_cnt[POS_W-1:0];
          out_LLR   <= norm_llr;
          out_cnt   <= out_cnt_inc;
          if (!base_valid) begin
            base       <= head_LLR;
            base_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire
